vend_fsm_param: RTL and testbench
=================================

# vend_fsm_param

Parametrised coin-operated vending controller: the next generation of the team's nickel/dime/quarter vending FSM. It accumulates credit from coin pulses against a programmable price and issues a one-cycle dispense pulse. It then pays change sequentially, one coin per cycle, using greedy quarter/dime/nickel order, and supports a cancel/refund request. It sits between the coin-acceptor front end (debounced, one-cycle coin pulses) and the product/coin-return actuators.

## Interface
- PRICE, 5, item price in nickel units (1..31); default 5 is 25 cents
- CW, $clog2(PRICE+5), credit/change register width; must hold PRICE+4
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- N  in  1  nickel inserted (one-cycle pulse)
- D  in  1  dime inserted (one-cycle pulse)
- Q  in  1  quarter inserted (one-cycle pulse)
- cancel  in  1  refund request (one-cycle pulse)
- Dispense  out  1  one-cycle product release pulse
- ReturnNickel  out  1  one-cycle pulse, return one nickel
- ReturnDime  out  1  one-cycle pulse, return one dime
- ReturnQuarter  out  1  one-cycle pulse, return one quarter
- CoinReject  out  1  one-cycle pulse, the coin(s) sampled last cycle are routed back uncredited
- busy  out  1  high in VEND or CHANGE
- credit  out  CW  current accumulated credit in nickels

## Operation
- Coin value in nickels: N=1, D=2, Q=5.
- A coin counts only if exactly one of N/D/Q is high in IDLE. Zero coins counts as no coin.
- Two or more coin inputs high, or any coin high while busy: CoinReject the next cycle, no credit change.
- States:
  - IDLE: accept coins.
  - VEND: Dispense high for exactly 1 cycle.
  - CHANGE: pay out the change register.
- IDLE, legal coin, credit+v < PRICE: credit += v, stay in IDLE.
- IDLE, legal coin, credit+v >= PRICE: change = credit+v-PRICE, credit returns to 0, go to VEND.
- VEND: go to CHANGE if change != 0, else go to IDLE.
- CHANGE: each cycle emit exactly one return pulse, largest first:
  - change >= 5: ReturnQuarter, change -= 5
  - else change >= 2: ReturnDime, change -= 2
  - else: ReturnNickel, change -= 1
  - Go to IDLE on the cycle change reaches 0.
- cancel in IDLE with credit > 0: change = credit, credit = 0, go to CHANGE with no Dispense.
  - cancel with a coin in the same cycle: the coin is rejected and the cancel is honoured.
  - cancel in IDLE with credit = 0: ignored.
  - cancel while busy: ignored.
- Maximum credit is PRICE+4. Credit never wraps. Change never exceeds 4 after a vend.
- Return pulses are mutually exclusive. Dispense never overlaps a return pulse.

## Timing
- All outputs are registered. Inputs are sampled on the rising edge of clk.
- Reset (reset=0 at an edge) forces, on that edge:
  - state IDLE
  - credit=0, change=0
  - all pulse outputs 0, busy=0
- Reset overrides everything, including mid-VEND and mid-CHANGE. Pending change is discarded.
- Coin sampled at edge k: credit updates at edge k+1.
- Vend coin sampled at edge k: Dispense high during cycle k+1..k+2.
- First change pulse is high in the cycle after Dispense. Further change pulses follow on consecutive cycles.
- Cancel sampled at edge k: first return pulse high in cycle k+1.
- CoinReject is high for the one cycle after the offending sample.
- busy is high from the cycle Dispense (or the first refund pulse) rises until the last return pulse ends.
- Back-to-back purchases: a coin is accepted in the first IDLE cycle after busy falls.

## Test plan
- PRICE=5: Q pulse → credit stays 0, Dispense 1 cycle at k+1, no return pulses, busy 1 cycle.
- PRICE=5: N, then Q → credit 1, then vend. Dispense, then ReturnNickel next cycle, then IDLE.
- PRICE=5: D, D, Q → credit 2, 4, then vend with change 4. Dispense, ReturnDime, ReturnDime, then IDLE.
- PRICE=10: Q, D, cancel → credit 5, 7, then refund sequence ReturnQuarter, ReturnDime. No Dispense; credit 0.
- Illegal/busy inputs: N+D in the same cycle → CoinReject, credit unchanged. Coin during CHANGE → CoinReject, change sequence unaffected. Cancel+N together in IDLE with credit 3 → CoinReject and refund of 3 (Dime, Nickel).
- Reset asserted in the middle of a CHANGE with 2 pulses pending → next cycle all outputs 0, credit 0, IDLE. A following Q (PRICE=5) vends normally.

Source files
------------

// File: rtl/vend_fsm_param.sv
// vend_fsm_param
//   Coin-operated vending controller with a programmable price. It accumulates
//   credit from single-cycle coin pulses, issues a one-cycle Dispense pulse once
//   the price is reached, then pays change one coin per cycle (quarter, dime,
//   nickel, largest first). A cancel in IDLE refunds the credit the same way.
//
//   Parameters
//     PRICE  item price in nickels (1..31)
//     CW     credit/change width, wide enough to hold PRICE+4
//
//   Ports
//     clk            rising-edge clock
//     reset          synchronous active-low reset
//     N, D, Q        nickel / dime / quarter pulses from the coin acceptor
//     cancel         refund request pulse
//     Dispense       one-cycle product release
//     ReturnNickel   one-cycle nickel return
//     ReturnDime     one-cycle dime return
//     ReturnQuarter  one-cycle quarter return
//     CoinReject     one-cycle pulse: last sampled coin(s) routed back uncredited
//     busy           high while dispensing or paying out
//     credit         accumulated credit in nickels
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | accepting coins and cancel
//   S_VEND   | Dispense is high this cycle
//   S_CHANGE | a return pulse is high this cycle; r_change holds what is left
//
//   Inputs go through one register stage first, so a coin sampled at edge k
//   is acted on at edge k+1. Every output is a flop.

module vend_fsm_param #(
  parameter int PRICE = 5,
  parameter int CW    = $clog2(PRICE + 5)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          N,
  input  logic          D,
  input  logic          Q,
  input  logic          cancel,
  output logic          Dispense,
  output logic          ReturnNickel,
  output logic          ReturnDime,
  output logic          ReturnQuarter,
  output logic          CoinReject,
  output logic          busy,
  output logic [CW-1:0] credit
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_n;
  logic          r_d;
  logic          r_q;
  logic          r_cancel;
  logic [CW-1:0] r_credit;
  logic [CW-1:0] r_change;
  logic          r_dispense;
  logic          r_ret_n;
  logic          r_ret_d;
  logic          r_ret_q;
  logic          r_reject;
  logic          r_busy;

  logic [1:0]    w_coin_cnt;
  logic          w_any_coin;
  logic          w_multi_coin;
  logic          w_one_coin;
  logic [CW-1:0] w_coin_val;
  logic [CW-1:0] w_sum;
  logic          w_vend;
  logic [CW-1:0] w_pay_src;
  logic          w_pay_q;
  logic          w_pay_d;
  logic          w_pay_n;
  logic [CW-1:0] w_pay_amt;
  logic [CW-1:0] w_pay_rem;

  assign w_coin_cnt   = {1'b0, r_n} + {1'b0, r_d} + {1'b0, r_q};
  assign w_any_coin   = r_n | r_d | r_q;
  assign w_multi_coin = (w_coin_cnt > 2'd1);
  assign w_one_coin   = (w_coin_cnt == 2'd1);

  assign w_coin_val = r_q ? CW'(5) :
                      r_d ? CW'(2) :
                      r_n ? CW'(1) : '0;

  // Credit in IDLE is always below PRICE, so the sum tops out at PRICE+4.
  assign w_sum  = r_credit + w_coin_val;
  assign w_vend = (w_sum >= CW'(PRICE));

  // One greedy payout step. In IDLE it is only used by a refund, which pays
  // from the credit; otherwise it pays from the change register.
  assign w_pay_src = (r_state == S_IDLE) ? r_credit : r_change;
  assign w_pay_q   = (w_pay_src >= CW'(5));
  assign w_pay_d   = !w_pay_q && (w_pay_src >= CW'(2));
  assign w_pay_n   = !w_pay_q && !w_pay_d && (w_pay_src != '0);
  assign w_pay_amt = w_pay_q ? CW'(5) :
                     w_pay_d ? CW'(2) :
                     w_pay_n ? CW'(1) : '0;
  assign w_pay_rem = w_pay_src - w_pay_amt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_n        <= 1'b0;
      r_d        <= 1'b0;
      r_q        <= 1'b0;
      r_cancel   <= 1'b0;
      r_credit   <= '0;
      r_change   <= '0;
      r_dispense <= 1'b0;
      r_ret_n    <= 1'b0;
      r_ret_d    <= 1'b0;
      r_ret_q    <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_n        <= N;
      r_d        <= D;
      r_q        <= Q;
      r_cancel   <= cancel;
      r_dispense <= 1'b0;
      r_ret_n    <= 1'b0;
      r_ret_d    <= 1'b0;
      r_ret_q    <= 1'b0;
      r_busy     <= 1'b0;

      // A coin is bounced if it is ambiguous, arrives while busy, or shares
      // its cycle with a cancel.
      r_reject <= w_any_coin &&
                  (w_multi_coin || (r_state != S_IDLE) || r_cancel);

      case (r_state)
        S_IDLE: begin
          if (r_cancel && (r_credit != '0)) begin
            // Refund: the first coin goes out right away.
            r_credit <= '0;
            r_ret_q  <= w_pay_q;
            r_ret_d  <= w_pay_d;
            r_ret_n  <= w_pay_n;
            r_change <= w_pay_rem;
            r_state  <= S_CHANGE;
            r_busy   <= 1'b1;
          end else if (w_one_coin && !r_cancel) begin
            if (w_vend) begin
              r_credit   <= '0;
              r_change   <= w_sum - CW'(PRICE);
              r_dispense <= 1'b1;
              r_state    <= S_VEND;
              r_busy     <= 1'b1;
            end else begin
              r_credit <= w_sum;
            end
          end
        end

        default: begin
          // S_VEND and S_CHANGE both drain the change register one coin per
          // cycle and fall back to IDLE once nothing is left.
          if (r_change != '0) begin
            r_ret_q  <= w_pay_q;
            r_ret_d  <= w_pay_d;
            r_ret_n  <= w_pay_n;
            r_change <= w_pay_rem;
            r_state  <= S_CHANGE;
            r_busy   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Dispense      = r_dispense;
  assign ReturnNickel  = r_ret_n;
  assign ReturnDime    = r_ret_d;
  assign ReturnQuarter = r_ret_q;
  assign CoinReject    = r_reject;
  assign busy          = r_busy;
  assign credit        = r_credit;

endmodule

// File: tb/tb_vend_fsm_param.sv
module tb_vend_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, N, D, Q, cancel;

  logic       disp5, rn5, rd5, rq5, rej5, busy5;
  logic [3:0] cr5;
  logic       disp10, rn10, rd10, rq10, rej10, busy10;
  logic [3:0] cr10;

  vend_fsm_param #(.PRICE(5)) dut5 (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
    .Dispense(disp5), .ReturnNickel(rn5), .ReturnDime(rd5),
    .ReturnQuarter(rq5), .CoinReject(rej5), .busy(busy5), .credit(cr5)
  );

  vend_fsm_param #(.PRICE(10)) dut10 (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
    .Dispense(disp10), .ReturnNickel(rn10), .ReturnDime(rd10),
    .ReturnQuarter(rq10), .CoinReject(rej10), .busy(busy10), .credit(cr10)
  );

  // exp packing: {Dispense, RetN, RetD, RetQ, CoinReject, busy, credit[3:0]}
  typedef struct {
    int         idx;
    bit         p10;
    bit         rst;
    bit         n, d, q, c;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(bit p10, bit rst, bit n, bit d, bit q, bit c,
                              bit disp, bit rn, bit rd, bit rq, bit rej,
                              bit bsy, int cr);
    vec_t v;
    v.idx = tbl.size();
    v.p10 = p10;
    v.rst = rst;
    v.n = n; v.d = d; v.q = q; v.c = c;
    v.exp = {disp, rn, rd, rq, rej, bsy, 4'(cr)};
    tbl.push_back(v);
  endfunction

  function automatic logic [9:0] observed(bit p10);
    if (p10) return {disp10, rn10, rd10, rq10, rej10, busy10, cr10};
    return {disp5, rn5, rd5, rq5, rej5, busy5, cr5};
  endfunction

  task automatic check(vec_t e);
    logic [9:0] got;
    got = observed(e.p10);
    n_cmp++;
    if (got !== e.exp) begin
      n_bad++;
      $display("FAIL row%0d p%0d: got %b want %b (disp,rn,rd,rq,rej,busy,credit)",
               e.idx, e.p10 ? 10 : 5, got, e.exp);
    end
  endtask

  // Outputs for a row appear two edges after it is driven (input register +
  // FSM flop), so the scoreboard is popped one step behind.
  task automatic step(vec_t v);
    vec_t e;
    reset  = !v.rst;
    N      = v.n;
    D      = v.d;
    Q      = v.q;
    cancel = v.c;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  initial begin
    vec_t e;
    vec_t rv;

    // ---- PRICE=5 ----
    // single quarter vends exactly
    add(0,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // N then Q: change 1
    add(0,0, 1,0,0,0, 0,0,0,0,0,0,1);
    add(0,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,1,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // D, D, Q: max change 4 -> two dimes
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,2);
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,4);
    add(0,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,1,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,1,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // N, then N+D rejected, then cancel refunds 1
    add(0,0, 1,0,0,0, 0,0,0,0,0,0,1);
    add(0,0, 1,1,0,0, 0,0,0,0,1,0,1);
    add(0,0, 0,0,0,1, 0,1,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // cancel with zero credit ignored
    add(0,0, 0,0,0,1, 0,0,0,0,0,0,0);
    // cancel in VEND ignored, coin in CHANGE rejected
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,2);
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,4);
    add(0,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(0,0, 0,0,0,1, 0,0,1,0,0,1,0);
    add(0,0, 1,0,0,0, 0,0,1,0,1,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // cancel+N with credit 3: reject and refund dime, nickel
    add(0,0, 1,0,0,0, 0,0,0,0,0,0,1);
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,3);
    add(0,0, 1,0,0,1, 0,0,1,0,1,1,0);
    add(0,0, 0,0,0,0, 0,1,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // reset mid-CHANGE discards pending dime, then Q vends normally
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,2);
    add(0,0, 0,1,0,0, 0,0,0,0,0,0,4);
    add(0,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,1,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1, 0,0,0,0, 0,0,0,0,0,0,0);
    add(0,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(0,0, 0,0,0,0, 0,0,0,0,0,0,0);

    // ---- PRICE=10 (reset first to clear whatever dut10 accumulated) ----
    add(1,1, 0,0,0,0, 0,0,0,0,0,0,0);
    // Q, D, cancel: refund 7 = quarter + dime
    add(1,0, 0,0,1,0, 0,0,0,0,0,0,5);
    add(1,0, 0,1,0,0, 0,0,0,0,0,0,7);
    add(1,0, 0,0,0,1, 0,0,0,1,0,1,0);
    add(1,0, 0,0,0,0, 0,0,1,0,0,1,0);
    add(1,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // Q, Q: exact
    add(1,0, 0,0,1,0, 0,0,0,0,0,0,5);
    add(1,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(1,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // credit 9 then Q: sum PRICE+4, change 4
    add(1,0, 0,1,0,0, 0,0,0,0,0,0,2);
    add(1,0, 0,1,0,0, 0,0,0,0,0,0,4);
    add(1,0, 0,1,0,0, 0,0,0,0,0,0,6);
    add(1,0, 0,1,0,0, 0,0,0,0,0,0,8);
    add(1,0, 1,0,0,0, 0,0,0,0,0,0,9);
    add(1,0, 1,1,1,0, 0,0,0,0,1,0,9);
    add(1,0, 0,0,1,0, 1,0,0,0,0,1,0);
    add(1,0, 0,0,0,0, 0,0,1,0,0,1,0);
    add(1,0, 0,0,0,0, 0,0,1,0,0,1,0);
    add(1,0, 0,0,0,0, 0,0,0,0,0,0,0);

    // ---- reset state ----
    reset = 1'b0; N = 1'b1; D = 1'b0; Q = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    N = 1'b0; Q = 1'b0; cancel = 1'b0;
    @(posedge clk); #1;
    rv.idx = -1; rv.p10 = 0; rv.rst = 1; rv.n = 0; rv.d = 0; rv.q = 0; rv.c = 0;
    rv.exp = '0;
    check(rv);
    rv.p10 = 1;
    check(rv);
    reset = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    N = 1'b0; D = 1'b0; Q = 1'b0; cancel = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
